// File: rtl/uart_rx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_byte : 8N1 serial receiver, 16x oversampled via clock enable,     |
// |                valid/ack output register with frame and overrun flags.    |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module uart_rx_byte #(
  parameter int OS_DIV    = 54,
  parameter int OS_RATE   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 rd_ack
);

  localparam int DIV_W = (OS_DIV > 0) ? $clog2(OS_DIV + 1) : 1;
  localparam int OS_W  = $clog2(OS_RATE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(OS_DIV);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  state_t               state;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  // Flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rd_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              state  <= S_START;
              os_cnt <= '0;
            end
          end
          S_START: begin
            if (os_cnt == OS_HALF) begin
              os_cnt  <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? S_IDLE : S_DATA;
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= S_STOP;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (os_cnt == OS_LAST) begin
              // Leaving mid stop bit lets a back-to-back start edge be seen.
              os_cnt     <= '0;
              state      <= S_IDLE;
              data_out   <= shreg;
              data_valid <= 1'b1;
              frame_err  <= ~rx_s;
              if (data_valid && !rd_ack) begin
                overrun <= 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// Self-checking bench for uart_rx_byte: directed frames plus random frames
// against a frame-level model of the output register and its handshake.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int OS_DIV    = 6;
  localparam int OS_RATE   = 16;
  localparam int DATA_BITS = 8;
  localparam int T         = OS_DIV + 1;
  localparam int BIT       = OS_RATE * T;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  int ncmp = 0;
  int nfail = 0;

  logic       mv, mf, mo;
  logic [7:0] md;

  always #5 clk = ~clk;

  uart_rx_byte #(
    .OS_DIV(OS_DIV),
    .OS_RATE(OS_RATE),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .overrun(overrun),
    .rd_ack(rd_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},  32'(data_out),   32'(md));
    check({tag, ".valid"}, 32'(data_valid), 32'(mv));
    check({tag, ".ferr"},  32'(frame_err),  32'(mf));
    check({tag, ".ovr"},   32'(overrun),    32'(mo));
  endtask

  task automatic model_reset();
    mv = 1'b0; mf = 1'b0; mo = 1'b0; md = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic stopv, input logic ack_same);
    if (ack_same) mo = 1'b0;
    else if (mv)  mo = 1'b1;
    md = b; mv = 1'b1; mf = ~stopv;
  endtask

  // Called at a negedge; ends at the negedge where the clear is visible.
  task automatic do_ack();
    @(negedge clk) rd_ack = 1'b1;
    @(negedge clk) rd_ack = 1'b0;
    if (mv) begin mv = 1'b0; mo = 1'b0; end
  endtask

  // Called at a negedge; one frame lasts exactly 10*BIT cycles.
  task automatic send_frame(input logic [7:0] b, input logic stopv);
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(negedge clk);
      rx = b[i];
    end
    repeat (BIT) @(negedge clk);
    rx = stopv;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       stopv;
    logic       prev_bad_stop;
    int         lat;

    model_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    send_frame(8'hA5, 1'b1);
    model_byte(8'hA5, 1'b1, 1'b0);
    check_all("a5");
    do_ack();
    check_all("a5_ack");

    rx = 1'b0;
    repeat (3 * T) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check_all("glitch");
    send_frame(8'h3C, 1'b1);
    model_byte(8'h3C, 1'b1, 1'b0);
    check_all("3c");
    do_ack();

    send_frame(8'hFF, 1'b0);
    model_byte(8'hFF, 1'b0, 1'b0);
    check_all("ferr");
    repeat (2 * BIT) @(negedge clk);
    do_ack();
    check_all("ferr_ack");

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    model_byte(8'h11, 1'b1, 1'b0);
    model_byte(8'h22, 1'b1, 1'b0);
    check_all("overrun");
    do_ack();
    check_all("overrun_ack");

    // Frames are 160 ticks apart, so the second completes exactly 10*BIT
    // cycles after the first; rd_ack is aimed at that cycle.
    b = 8'($urandom);
    fork
      begin
        send_frame(b, 1'b1);
        send_frame(8'h55, 1'b1);
      end
      begin
        lat = 0;
        while (!data_valid && lat < 3000) begin
          @(negedge clk);
          lat++;
        end
        // Detection tick lands 2..T+1 cycles after the edge, plus 152 ticks
        // to the update and one cycle to see it.
        check("latency", 32'((lat >= 3 + 152 * T) && (lat <= 2 + 153 * T)), 32'd1);
        if (data_valid) begin
          repeat (10 * BIT - 1) @(negedge clk);
          rd_ack = 1'b1;
          @(negedge clk);
          rd_ack = 1'b0;
        end
      end
    join
    model_byte(b, 1'b1, 1'b0);
    model_byte(8'h55, 1'b1, 1'b1);
    check_all("collision");
    do_ack();

    prev_bad_stop = 1'b0;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      stopv = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, BIT) + (prev_bad_stop ? 2 * BIT : 0)) @(negedge clk);
      send_frame(b, stopv);
      model_byte(b, stopv, 1'b0);
      check_all("rand");
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        check_all("rand_ack");
      end
      prev_bad_stop = ~stopv;
    end
    repeat (2 * BIT) @(negedge clk);

    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("rst_mid");
      end
    join
    check("rst_mid.noc3", 32'(data_out == 8'hC3), 32'd0);
    // Low data bits after reset may resync as a stray frame; flush it.
    repeat (12 * BIT) @(negedge clk);
    if (data_valid) do_ack();
    model_reset();
    send_frame(8'h81, 1'b1);
    model_byte(8'h81, 1'b1, 1'b0);
    check_all("81");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
